pr_icap_writer: RTL and testbench

PR_ICAP_WRITER -- requirements
Module: pr_icap_writer

---
 rtl/pr_icap_writer.sv | 176 +++++++++++++++++
 tb/tb_pr_icap_writer.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pr_icap_writer.sv
// pr_icap_writer: feeds a partial-reconfiguration bitstream into ICAP and tracks PRDONE/PRERROR.
// Define PR_ICAP_BITSWAP_EN to reverse the bit order inside each byte of icap_din.
module pr_icap_writer #(
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic        icap_clk,
  input  logic        icap_rst,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  input  logic        abort,
  output logic        icap_csib,
  output logic        icap_rdwrb,
  output logic [31:0] icap_din,
  input  logic [3:0]  icap_pr_status,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [31:0] word_count
);

  localparam int unsigned   TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WRITE, S_FLUSH, S_WAIT_DONE, S_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_PRERROR = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_ABORT   = 2'd3
  } err_t;

  state_t        state_q, state_d;
  logic          csib_q, csib_d;
  logic          rdwrb_q, rdwrb_d;
  logic [31:0]   din_q, din_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  err_t          code_q, code_d;
  logic [31:0]   wc_q, wc_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic prdone, avail, prerror, status_unused;
  logic hs;

  assign {status_unused, prerror, avail, prdone} = icap_pr_status;

  function automatic logic [31:0] map_word(input logic [31:0] w);
    logic [31:0] r;
`ifdef PR_ICAP_BITSWAP_EN
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[8*b + i] = w[8*b + 7 - i];
      end
    end
`else
    r = w;
`endif
    return r;
  endfunction

  assign s_ready = ((state_q == S_WRITE) && avail) || (state_q == S_DRAIN);
  assign hs      = s_valid && s_ready;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    csib_d  = 1'b1;
    din_d   = din_q;
    done_d  = 1'b0;
    error_d = error_q;
    code_d  = code_q;
    wc_d    = wc_q;
    tmo_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (s_valid && avail && !abort) begin
          state_d = S_ARM;
          error_d = 1'b0;
          code_d  = ERR_NONE;
          wc_d    = '0;
        end
      end
      S_ARM: state_d = S_WRITE;
      S_WRITE: begin
        if (hs) begin
          din_d  = map_word(s_data);
          csib_d = 1'b0;
          if (wc_q != '1) wc_d = wc_q + 32'd1;
          if (s_last) state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_d == TMO_LIMIT) begin
          state_d = S_IDLE;
          error_d = 1'b1;
          code_d  = ERR_TIMEOUT;
        end else if (prdone) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (hs && s_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Later overrides win, so they are applied lowest priority first.
    if (prerror && (state_q inside {S_ARM, S_WRITE, S_FLUSH, S_WAIT_DONE})) begin
      csib_d  = 1'b1;
      din_d   = din_q;
      wc_d    = wc_q;
      done_d  = 1'b0;
      error_d = 1'b1;
      code_d  = ERR_PRERROR;
      state_d = ((state_q inside {S_ARM, S_WRITE}) && !(hs && s_last)) ? S_DRAIN : S_IDLE;
    end

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      csib_d  = 1'b1;
      din_d   = din_q;
      wc_d    = wc_q;
      done_d  = 1'b0;
      error_d = 1'b1;
      code_d  = error_q ? code_q : ERR_ABORT;
    end

    // Direction follows the next state; every transition that flips it also deasserts csib.
    rdwrb_d = !(state_d inside {S_ARM, S_WRITE, S_FLUSH});
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge icap_clk) begin
    if (icap_rst) begin
      state_q <= S_IDLE;
      csib_q  <= 1'b1;
      rdwrb_q <= 1'b1;
      din_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      code_q  <= ERR_NONE;
      wc_q    <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      csib_q  <= csib_d;
      rdwrb_q <= rdwrb_d;
      din_q   <= din_d;
      done_q  <= done_d;
      error_q <= error_d;
      code_q  <= code_d;
      wc_q    <= wc_d;
      tmo_q   <= tmo_d;
    end
  end

  assign icap_csib  = csib_q;
  assign icap_rdwrb = rdwrb_q;
  assign icap_din   = din_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = code_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_pr_icap_writer.sv
// Self-checking bench for pr_icap_writer: scenario tasks drive random streams and compare the
// ICAP write trace, status flags and counters against a transaction-level expectation.
module tb_pr_icap_writer;

  localparam int TMO    = 16;
  localparam int BUDGET = 200;

  logic        icap_clk = 1'b0;
  logic        icap_rst;
  logic [31:0] s_data;
  logic        s_valid, s_last, s_ready, abort;
  logic        icap_csib, icap_rdwrb;
  logic [31:0] icap_din;
  logic [3:0]  icap_pr_status;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [31:0] word_count;

  logic prerror_r, avail_r, prdone_r;
  assign icap_pr_status = {1'b0, prerror_r, avail_r, prdone_r};

  pr_icap_writer #(.TIMEOUT_CYCLES(TMO)) dut (
    .icap_clk      (icap_clk),
    .icap_rst      (icap_rst),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .abort         (abort),
    .icap_csib     (icap_csib),
    .icap_rdwrb    (icap_rdwrb),
    .icap_din      (icap_din),
    .icap_pr_status(icap_pr_status),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_code      (err_code),
    .word_count    (word_count)
  );

  always #5 icap_clk = ~icap_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [31:0] words[$];
  logic [31:0] got[$];
  int          got_cyc[$];
  logic        prev_rdwrb = 1'b1;

  always @(posedge icap_clk) cyc++;

  // Passive ICAP monitor: records every written word and checks the direction protocol.
  always @(negedge icap_clk) begin
    if (!icap_rst) begin
      if (icap_csib === 1'b0) begin
        got.push_back(icap_din);
        got_cyc.push_back(cyc);
        checks++;
        if (icap_rdwrb !== 1'b0) begin
          errors++;
          $display("FAIL rdwrb_on_write: rdwrb=%b required 0", icap_rdwrb);
        end
      end
      if (icap_rdwrb !== prev_rdwrb) begin
        checks++;
        if (icap_csib !== 1'b1) begin
          errors++;
          $display("FAIL rdwrb_change: csib=%b during rdwrb change, required 1", icap_csib);
        end
      end
      if (done === 1'b1) done_cnt++;
    end
    prev_rdwrb = icap_rdwrb;
  end

  // Expected ICAP image of a stream word: optionally each byte mirrored, byte order unchanged.
  function automatic logic [31:0] exp_map(input logic [31:0] w);
    logic [31:0] r;
    logic [7:0]  b;
    r = w;
`ifdef PR_ICAP_BITSWAP_EN
    for (int k = 0; k < 4; k++) begin
      b = w[8*k +: 8];
      r[8*k +: 8] = {<<{b}};
    end
`endif
    return r;
  endfunction

  // -1: trace equals the first nexp mapped words; -2: wrong length; else first bad index.
  function automatic int first_bad(input int nexp);
    if (got.size() != nexp) return -2;
    for (int i = 0; i < nexp; i++) if (got[i] !== exp_map(words[i])) return i;
    return -1;
  endfunction

  task automatic clear_trace();
    got.delete();
    got_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  task automatic tick();
    @(posedge icap_clk);
    #1;
  endtask

  // Drives words[0..n-1]; optional avail stall, prerror pulse or abort pulse after word index.
  task automatic drive_stream(input int n, input int stall_after, input int stall_len,
                              input int err_after, input int abort_after, output int acc);
    int idx = 0;
    int stall = 0;
    int cycles = 0;
    bit err_pend = 0;
    bit abt_pend = 0;
    bit hs;
    while (idx < n && cycles < BUDGET) begin
      s_valid   = 1'b1;
      s_data    = words[idx];
      s_last    = (idx == n - 1);
      avail_r   = (stall == 0);
      prerror_r = err_pend;
      abort     = abt_pend;
      err_pend  = 0;
      #1;
      if (stall != 0) begin
        checks++;
        if (s_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_ready: s_ready=%b required 0", s_ready);
        end
      end
      hs = (s_ready === 1'b1);
      tick();
      cycles++;
      if (stall != 0) stall--;
      if (abt_pend) begin
        abt_pend = 0;
        break;
      end
      if (hs) begin
        if (idx == stall_after) stall = stall_len;
        if (idx == err_after) err_pend = 1;
        if (idx == abort_after) abt_pend = 1;
        idx++;
      end
    end
    s_valid = 1'b0; s_last = 1'b0; avail_r = 1'b1; prerror_r = 1'b0; abort = 1'b0;
    if (err_pend) begin
      prerror_r = 1'b1;
      tick();
      prerror_r = 1'b0;
    end
    if (cycles >= BUDGET) begin
      checks++;
      errors++;
      $display("FAIL drive_budget: stream stuck at word %0d of %0d", idx, n);
    end
    acc = idx;
  endtask

  task automatic pulse_prdone(input int delay);
    repeat (delay) tick();
    prdone_r = 1'b1;
    tick();
    prdone_r = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    icap_rst = 1'b1;
    s_valid = 0; s_last = 0; s_data = '0; abort = 0;
    prerror_r = 0; avail_r = 1; prdone_r = 0;
    repeat (3) tick();
    checks++;
    if ({icap_csib, icap_rdwrb, s_ready, busy, done, error} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_flags: csib,rdwrb,ready,busy,done,error=%b required 110000",
               {icap_csib, icap_rdwrb, s_ready, busy, done, error});
    end
    checks++;
    if (icap_din !== 32'h0 || err_code !== 2'd0 || word_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: din=%h err_code=%0d word_count=%0d required 0/0/0",
               icap_din, err_code, word_count);
    end
    icap_rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int acc, bad;
    clear_trace();
    words = '{32'hFFFF_FFFF, 32'hAA99_5566, 32'h2000_0000};
    drive_stream(3, -1, 0, -1, -1, acc);
    pulse_prdone(5);
    bad = first_bad(3);
    checks++;
    if (bad != -1) begin
      errors++;
      $display("FAIL basic_writes: bad index %0d, got %0d words required 3", bad, got.size());
    end else begin
      checks++;
      if (got_cyc[2] - got_cyc[0] != 2) begin
        errors++;
        $display("FAIL basic_consecutive: writes span %0d cycles required 2",
                 got_cyc[2] - got_cyc[0]);
      end
    end
    checks++;
    if (done_cnt != 1 || word_count !== 32'd3 || error !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_status: done_cnt=%0d wc=%0d error=%b busy=%b required 1/3/0/0",
               done_cnt, word_count, error, busy);
    end
  endtask

  task automatic test_stall();
    int acc, bad;
    clear_trace();
    rand_words(3);
    drive_stream(3, 0, 2, -1, -1, acc);
    pulse_prdone(3);
    bad = first_bad(3);
    checks++;
    if (bad != -1) begin
      errors++;
      $display("FAIL stall_writes: bad index %0d, got %0d words required 3", bad, got.size());
    end else begin
      checks++;
      if (got_cyc[1] - got_cyc[0] != 3) begin
        errors++;
        $display("FAIL stall_gap: write gap %0d cycles required 3", got_cyc[1] - got_cyc[0]);
      end
    end
    checks++;
    if (word_count !== 32'd3 || done_cnt != 1) begin
      errors++;
      $display("FAIL stall_status: wc=%0d done_cnt=%0d required 3/1", word_count, done_cnt);
    end
  endtask

  task automatic test_timeout();
    int acc;
    clear_trace();
    rand_words(2);
    drive_stream(2, -1, 0, -1, -1, acc);
    repeat (TMO) tick();
    checks++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: busy=%b error=%b after %0d waits required 1/0",
               busy, error, TMO - 1);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || error !== 1'b1 || err_code !== 2'd2 || done_cnt != 0) begin
      errors++;
      $display("FAIL timeout_flag: busy=%b error=%b err_code=%0d done_cnt=%0d required 0/1/2/0",
               busy, error, err_code, done_cnt);
    end
  endtask

  // prerror raised in the cycle after word e: ICAP receives words 0..e, the rest is discarded.
  task automatic run_prerror(input string name, input int n, input int e);
    int acc, bad;
    clear_trace();
    rand_words(n);
    drive_stream(n, -1, 0, e, -1, acc);
    bad = first_bad(e + 1);
    checks++;
    if (bad != -1) begin
      errors++;
      $display("FAIL %s_writes: bad index %0d, got %0d words required %0d",
               name, bad, got.size(), e + 1);
    end
    checks++;
    if (busy !== 1'b0 || error !== 1'b1 || err_code !== 2'd1 || word_count !== 32'(e + 1)) begin
      errors++;
      $display("FAIL %s_status: busy=%b error=%b err_code=%0d wc=%0d required 0/1/1/%0d",
               name, busy, error, err_code, word_count, e + 1);
    end
  endtask

  task automatic test_prerror();
    run_prerror("prerror", 5, 1);
    for (int it = 0; it < 3; it++) begin
      int n = $urandom_range(3, 7);
      run_prerror("prerror_rand", n, $urandom_range(0, n - 1));
    end
  endtask

  task automatic test_abort();
    int acc, bad;
    clear_trace();
    rand_words(5);
    drive_stream(5, -1, 0, -1, 1, acc);
    checks++;
    if ({busy, icap_csib, icap_rdwrb, s_ready, error} !== 5'b01101 || err_code !== 2'd3) begin
      errors++;
      $display("FAIL abort_state: busy,csib,rdwrb,ready,error=%b err_code=%0d required 01101/3",
               {busy, icap_csib, icap_rdwrb, s_ready, error}, err_code);
    end
    bad = first_bad(2);
    checks++;
    if (bad != -1 || word_count !== 32'd2) begin
      errors++;
      $display("FAIL abort_writes: bad=%0d wc=%0d required -1/2", bad, word_count);
    end
    clear_trace();
    rand_words(2);
    drive_stream(2, -1, 0, -1, -1, acc);
    checks++;
    if (error !== 1'b0 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL abort_clear: error=%b err_code=%0d required 0/0", error, err_code);
    end
    pulse_prdone(2);
    checks++;
    if (done_cnt != 1 || word_count !== 32'd2) begin
      errors++;
      $display("FAIL abort_restart: done_cnt=%0d wc=%0d required 1/2", done_cnt, word_count);
    end
  endtask

  task automatic test_priority();
    int acc;
    // abort while draining keeps the original PRERROR code
    clear_trace();
    rand_words(4);
    drive_stream(4, -1, 0, 0, 1, acc);
    checks++;
    if (busy !== 1'b0 || error !== 1'b1 || err_code !== 2'd1 || word_count !== 32'd1) begin
      errors++;
      $display("FAIL abort_in_error: busy=%b error=%b err_code=%0d wc=%0d required 0/1/1/1",
               busy, error, err_code, word_count);
    end
    // prdone together with prerror is an error
    clear_trace();
    rand_words(2);
    drive_stream(2, -1, 0, -1, -1, acc);
    repeat (2) tick();
    prdone_r = 1'b1; prerror_r = 1'b1;
    tick();
    prdone_r = 1'b0; prerror_r = 1'b0;
    tick();
    checks++;
    if (done_cnt != 0 || error !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL prdone_vs_prerror: done_cnt=%0d error=%b err_code=%0d busy=%b required 0/1/1/0",
               done_cnt, error, err_code, busy);
    end
    // prdone outside WAIT_DONE is ignored
    clear_trace();
    prdone_r = 1'b1;
    repeat (3) tick();
    rand_words(4);
    drive_stream(4, -1, 0, -1, -1, acc);
    repeat (2) tick();
    prdone_r = 1'b0;
    tick();
    checks++;
    if (done_cnt != 1 || first_bad(4) != -1 || error !== 1'b0) begin
      errors++;
      $display("FAIL prdone_ignored: done_cnt=%0d writes=%0d error=%b required 1/4/0",
               done_cnt, got.size(), error);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      int acc, bad;
      int n = $urandom_range(1, 8);
      clear_trace();
      rand_words(n);
      drive_stream(n, $urandom_range(0, n - 1), $urandom_range(0, 3), -1, -1, acc);
      pulse_prdone($urandom_range(1, 10));
      bad = first_bad(n);
      checks++;
      if (bad != -1 || word_count !== 32'(n) || done_cnt != 1 || error !== 1'b0) begin
        errors++;
        $display("FAIL random_%0d: bad=%0d wc=%0d done_cnt=%0d error=%b required -1/%0d/1/0",
                 it, bad, word_count, done_cnt, error, n);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    rand_words(4);
    s_valid = 1'b1; s_data = words[0]; avail_r = 1'b1;
    while (icap_csib !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    icap_rst = 1'b1;
    tick();
    checks++;
    if ({icap_csib, icap_rdwrb, busy, s_ready} !== 4'b1100 || word_count !== 32'd0 || n >= 20) begin
      errors++;
      $display("FAIL reset_mid: csib,rdwrb,busy,ready=%b wc=%0d wait=%0d required 1100/0/<20",
               {icap_csib, icap_rdwrb, busy, s_ready}, word_count, n);
    end
    s_valid = 1'b0;
    icap_rst = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_timeout();
    test_prerror();
    test_abort();
    test_priority();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
